// File: rtl/xor_share_arbiter.sv
// Shares one combinational XOR unit among NREQ requesters: arbitrate, drive a/b, capture, respond.
// Optional build macro XOR_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module xor_share_arbiter #(
    parameter int N    = 2,
    parameter int NREQ = 4,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic [N-1:0]      xor_a,
    output logic [N-1:0]      xor_b,
    input  logic [N-1:0]      xor_out,
    output logic              rsp_valid,
    output logic [IW-1:0]     rsp_id,
    output logic [N-1:0]      rsp_data,
    input  logic              rsp_ready
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state;

    logic [N-1:0]  a_sl [NREQ];
    logic [N-1:0]  b_sl [NREQ];
    logic [IW-1:0] grant;
    logic          grant_vld;

    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign a_sl[i] = req_a[i*N +: N];
        assign b_sl[i] = req_b[i*N +: N];
    end

`ifdef XOR_ARB_FIXED_PRIO_EN
    // Scan high to low so the lowest valid index wins.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                grant     = IW'(k);
                grant_vld = 1'b1;
            end
        end
    end
`else
    logic [IW-1:0] ptr;
    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    // Search ptr, ptr+1, ... with wrap; first valid requester wins.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(NREQ))
                sum = sum - (IW+1)'(NREQ);
            idx = sum[IW-1:0];
            if (!grant_vld && req_valid[idx]) begin
                grant     = idx;
                grant_vld = 1'b1;
            end
        end
    end
`endif

    // Gated by rst_n so ready is forced low while reset is held.
    always_comb begin
        req_ready = '0;
        if (rst_n && state == IDLE && grant_vld)
            req_ready[grant] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            xor_a     <= '0;
            xor_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
`ifndef XOR_ARB_FIXED_PRIO_EN
            ptr       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        xor_a  <= a_sl[grant];
                        xor_b  <= b_sl[grant];
                        rsp_id <= grant;
`ifndef XOR_ARB_FIXED_PRIO_EN
                        ptr    <= (grant == IW'(NREQ - 1)) ? '0 : grant + 1'b1;
`endif
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= xor_out;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xor_share_arbiter.sv
// Self-checking bench for xor_share_arbiter: transaction-level reference model plus directed tables/sequences.
module tb_xor_share_arbiter;
    localparam int N    = 2;
    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a = '0;
    logic [NREQ*N-1:0] req_b = '0;
    logic [N-1:0]      xor_a, xor_b, xor_out;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [N-1:0]      rsp_data;
    logic              rsp_ready = 1'b0;

    xor_share_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .xor_a(xor_a), .xor_b(xor_b), .xor_out(xor_out),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_ready(rsp_ready)
    );

    // The shared combinational XOR unit.
    assign xor_out = xor_a ^ xor_b;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: arbiter is either free or holding one accepted request.
    int         cyc = 0;
    bit         busy = 0;
    int         acc_cyc = 0;
    int         m_id = 0;
    logic [1:0] m_data = '0;
    int         mptr = 0;

    int         got_rsp = 0;
    int         seen_id = 0;
    logic [1:0] seen_data = '0;
    int         g_id[$];
    int         g_cyc[$];
    logic [1:0] r_data[$];

    typedef struct {
        logic [3:0] v;
        logic [7:0] a;
        logic [7:0] b;
        int         eid;
        logic [1:0] ed;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic int mgrant(input logic [NREQ-1:0] v, input int p);
        int i;
`ifdef XOR_ARB_FIXED_PRIO_EN
        p = 0;
`endif
        for (int k = 0; k < NREQ; k++) begin
            i = (p + k) % NREQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Called at posedge+1: drive, check at negedge, update model, return at next posedge+1.
    task automatic step(input logic [3:0] v, input logic [7:0] a, input logic [7:0] b, input logic rr);
        int g, dg;
        logic [NREQ-1:0] er;
        bit ev;
        req_valid = v; req_a = a; req_b = b; rsp_ready = rr;
        @(negedge clk);
        g  = busy ? -1 : mgrant(v, mptr);
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        ev = busy && (cyc >= acc_cyc + 2);
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("rsp_valid", 32'(rsp_valid), 32'(ev));
        if (ev) begin
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
            chk("rsp_data", 32'(rsp_data), 32'(m_data));
        end
        dg = -1;
        for (int k = 0; k < NREQ; k++)
            if (req_ready[k] && v[k]) dg = k;
        if (dg >= 0) begin
            g_id.push_back(dg);
            g_cyc.push_back(cyc);
        end
        if (rsp_valid && rr) begin
            got_rsp   = 1;
            seen_id   = int'(rsp_id);
            seen_data = rsp_data;
            r_data.push_back(rsp_data);
        end
        if (ev && rr) begin
            busy = 0;
        end else if (g >= 0) begin
            busy    = 1;
            acc_cyc = cyc;
            m_id    = g;
            m_data  = a[g*N +: N] ^ b[g*N +: N];
            mptr    = (g + 1) % NREQ;
        end
        cyc++;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        busy = 0;
        mptr = 0;
    endtask

    // Present v until accepted, then drop it and wait for the response.
    task automatic run_one(input logic [3:0] v, input logic [7:0] a, input logic [7:0] b,
                           output int gid, output int rid, output logic [1:0] d);
        int n;
        n = g_id.size();
        got_rsp = 0;
        gid = -1; rid = -1; d = '0;
        for (int k = 0; k < 8 && g_id.size() == n; k++) step(v, a, b, 1'b1);
        if (g_id.size() == n) begin
            chk("accept_timeout", 0, 1);
            return;
        end
        gid = g_id[n];
        for (int k = 0; k < 8 && got_rsp == 0; k++) step(4'b0, 8'h0, 8'h0, 1'b1);
        if (got_rsp == 0) begin
            chk("rsp_timeout", 0, 1);
            return;
        end
        rid = seen_id;
        d   = seen_data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int gid, rid, n, m, c0;
        logic [1:0] d;

        tbl[0] = '{4'b0010, 8'h08, 8'h0C, 1, 2'b01};
`ifdef XOR_ARB_FIXED_PRIO_EN
        tbl[1] = '{4'b1111, 8'hE4, 8'hFF, 0, 2'b11};
        tbl[2] = '{4'b0011, 8'hE4, 8'hFF, 0, 2'b11};
        tbl[3] = '{4'b1001, 8'hE4, 8'hFF, 0, 2'b11};
`else
        tbl[1] = '{4'b1111, 8'hE4, 8'hFF, 2, 2'b01};
        tbl[2] = '{4'b0011, 8'hE4, 8'hFF, 0, 2'b11};
        tbl[3] = '{4'b1001, 8'hE4, 8'hFF, 3, 2'b00};
`endif
        tbl[4] = '{4'b1000, 8'h40, 8'h80, 3, 2'b11};

        // Reset state
        #2;
        chk("reset_req_ready", 32'(req_ready), 0);
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_rsp_data", 32'(rsp_data), 0);
        chk("reset_xor_a", 32'(xor_a), 0);
        do_reset();

        // Table-driven single transactions (pointer carries between rows)
        for (int i = 0; i < 5; i++) begin
            run_one(tbl[i].v, tbl[i].a, tbl[i].b, gid, rid, d);
            chk("tbl_grant", 32'(gid), 32'(tbl[i].eid));
            chk("tbl_rsp_id", 32'(rid), 32'(tbl[i].eid));
            chk("tbl_rsp_data", 32'(d), 32'(tbl[i].ed));
        end

        // Fairness / throughput: all requesting, grants every 3 cycles
        do_reset();
        n = g_id.size(); m = r_data.size(); c0 = cyc;
        repeat (15) step(4'b1111, 8'hE4, 8'hFF, 1'b1);
        if (g_id.size() < n + 5 || r_data.size() < m + 5) begin
            chk("fair_count", 0, 1);
        end else begin
            for (int k = 0; k < 5; k++) begin
`ifdef XOR_ARB_FIXED_PRIO_EN
                chk("fair_grant", 32'(g_id[n+k]), 0);
                chk("fair_data", 32'(r_data[m+k]), 32'(2'b11));
`else
                chk("fair_grant", 32'(g_id[n+k]), 32'(k % 4));
                chk("fair_data", 32'(r_data[m+k]), 32'(2'(k % 4) ^ 2'b11));
`endif
                chk("fair_cycle", 32'(g_cyc[n+k] - c0), 32'(3 * k));
            end
        end
        for (int k = 0; k < 8 && busy; k++) step(4'b0, 8'h0, 8'h0, 1'b1);

`ifndef XOR_ARB_FIXED_PRIO_EN
        // Pointer wrap
        do_reset();
        run_one(4'b0100, 8'h00, 8'h00, gid, rid, d);
        chk("wrap_g2", 32'(gid), 2);
        run_one(4'b0001, 8'h01, 8'h02, gid, rid, d);
        chk("wrap_g0", 32'(gid), 0);
        chk("wrap_d0", 32'(d), 32'(2'b11));
        run_one(4'b0100, 8'h00, 8'h00, gid, rid, d);
        run_one(4'b1001, 8'h00, 8'hC0, gid, rid, d);
        chk("wrap_g3", 32'(gid), 3);
        chk("wrap_d3", 32'(d), 32'(2'b11));
`endif

        // Backpressure: hold RESP with rsp_ready low
        do_reset();
        step(4'b0001, 8'h02, 8'h01, 1'b1);
        step(4'b0000, 8'h00, 8'h00, 1'b0);
        repeat (5) step(4'b1111, 8'hFF, 8'h00, 1'b0);
        n = g_id.size();
        step(4'b1111, 8'hFF, 8'h00, 1'b1);
        c0 = cyc;
        step(4'b1111, 8'hFF, 8'h00, 1'b1);
        chk("bp_new_accept", 32'(g_id.size()), 32'(n + 1));
        if (g_id.size() > n) chk("bp_accept_cycle", 32'(g_cyc[n]), 32'(c0));
        for (int k = 0; k < 8 && busy; k++) step(4'b0, 8'h0, 8'h0, 1'b1);

        // Reset during EXEC drops the transaction
        do_reset();
        step(4'b0010, 8'h0C, 8'h04, 1'b1);
        rst_n = 1'b0;
        req_valid = 4'b0101;
        #1;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        busy = 0; mptr = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_one(4'b0101, 8'h31, 8'h12, gid, rid, d);
        chk("rst_grant0", 32'(gid), 0);
        chk("rst_rsp_id", 32'(rid), 0);
        chk("rst_rsp_data", 32'(d), 32'(2'b11));

`ifdef XOR_ARB_FIXED_PRIO_EN
        // Fixed priority: 1 always beats 3
        do_reset();
        n = g_id.size();
        repeat (9) step(4'b1010, 8'h00, 8'h00, 1'b1);
        for (int k = n; k < g_id.size(); k++) chk("fp_grant1", 32'(g_id[k]), 1);
        for (int k = 0; k < 8 && busy; k++) step(4'b0, 8'h0, 8'h0, 1'b1);
        run_one(4'b1000, 8'h00, 8'h00, gid, rid, d);
        chk("fp_grant3", 32'(gid), 3);
`endif

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++)
            step(4'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 3) != 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/xor_share_arbiter.md
# xor_share_arbiter

Sequencer and round-robin arbiter that shares one combinational N-bit XOR unit among NREQ requesters in the multiplier basic library. It accepts one request at a time over a valid/ready handshake, drives the shared XOR unit's `a`/`b` inputs from registers, and captures its `out`. It returns the result with the requester's index over a second valid/ready handshake. It sits between the partial-product/sum stages that need XOR and the single XOR instance, which it drives through the `xor_port` modport of the N-bit XOR interface.

## Interface
- `N`, 2, data width of operands and result
- `NREQ`, 4, number of requesters (≥2); `IW = $clog2(NREQ)`

- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  NREQ  per-requester request valid
- `req_ready`  out  NREQ  per-requester accept (one-hot or zero)
- `req_a`  in  NREQ*N  operand A, slice i = bits [i*N +: N]
- `req_b`  in  NREQ*N  operand B, same slicing
- `xor_a`  out  N  to shared XOR unit `a`
- `xor_b`  out  N  to shared XOR unit `b`
- `xor_out`  in  N  from shared XOR unit `out` (combinational)
- `rsp_valid`  out  1  result valid
- `rsp_id`  out  IW  index of the served requester
- `rsp_data`  out  N  `req_a ^ req_b` of the served request
- `rsp_ready`  in  1  downstream accepts result

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state: IDLE.
- IDLE:
  - Grant g = first i with `req_valid[i]`=1, searching ptr, ptr+1, …, NREQ-1, 0, … (wrap).
  - `req_ready[g]`=1 combinationally; all other bits 0. No valid → `req_ready`=0 and stay in IDLE.
  - On handshake (`req_valid[g]` & `req_ready[g]`): register `xor_a`←`req_a[g]`, `xor_b`←`req_b[g]`, `rsp_id`←g, ptr←(g+1) mod NREQ, then go to EXEC.
- EXEC: `req_ready`=0. Register `rsp_data`←`xor_out`, set `rsp_valid`=1, then go to RESP.
- RESP: `req_ready`=0. `rsp_valid`, `rsp_id` and `rsp_data` are held stable. When `rsp_ready`=1: clear `rsp_valid` and go to IDLE. No new accept happens in that same cycle.
- Requesters may drop `req_valid` before acceptance. Arbitration is re-evaluated every IDLE cycle; nothing is latched before the handshake.
- `xor_a`/`xor_b` keep their last values outside EXEC; the XOR unit's output is only sampled in EXEC.
- Widths: no truncation or extension. The result is exactly N bits.

## Timing
- Reset values (asynchronous, while `rst_n`=0): `req_ready`=0 (forced, overriding the combinational grant), `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `xor_a`=0, `xor_b`=0, ptr=0, state IDLE.
- Latency: handshake in cycle T, then `rsp_valid`=1 from cycle T+2.
- Throughput: with `rsp_ready` held high, one accept every 3 cycles (T, T+3, …).
- Backpressure: `rsp_ready`=0 holds RESP indefinitely with outputs stable and all `req_ready`=0.
- Reset mid-operation (EXEC or RESP): the transaction is dropped with no response, ptr returns to 0, and IDLE is entered on the first clock after release.
- Wrap: grant to NREQ-1 sets ptr=0.

## Configuration
- `XOR_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority. g = lowest index with `req_valid`=1, and ptr is not implemented.
  - Undefined (default): round-robin as described above.
  - All other behaviour and timing are identical in both modes.

## Test plan
- Single request: N=2, only `req_valid[1]`, `req_a[1]`=2'b10, `req_b[1]`=2'b11, handshake at cycle 0 → `rsp_valid`=1 at cycle 2 with `rsp_id`=1 and `rsp_data`=2'b01.
- Round-robin fairness: all 4 `req_valid` held high, `rsp_ready`=1, operands a=i, b=2'b11 → grant order 0,1,2,3,0 at cycles 0,3,6,9,12, with `rsp_data`=2'b11,2'b10,2'b01,2'b00.
- Pointer wrap: grant to 2, then only `req_valid[0]` high → next grant is 0. With `req_valid[0]` and `req_valid[3]` both high → next grant is 3.
- Backpressure: `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid`/`rsp_id`/`rsp_data` stable and `req_ready`=0 throughout. `rsp_ready`=1 → `rsp_valid`=0 the next cycle, and a new accept is possible the cycle after.
- Reset mid-EXEC: assert `rst_n`=0 asynchronously → `rsp_valid`=0 and `req_ready`=0 immediately, no response for the dropped request. After release, requests 0 and 2 valid → grant 0 (ptr=0).
- `XOR_ARB_FIXED_PRIO_EN` defined: requests 1 and 3 held high → every grant is 1, and requester 3 is served only once request 1 drops.
